// File: rtl/memory_mc.sv
// rtl/memory_mc.sv - multi-cycle Memory-stage data array with pipeline stall and done/err pulses
// Optional misaligned-access fault (commit suppressed, err pulsed) enabled by MEM_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module memory_mc #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] aluOut,
  input  logic [DATA_W-1:0] wrData,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              halt,
  output logic [DATA_W-1:0] memoryOut,
  output logic              stall,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, nextState;
  logic [3:0]              counter;
  logic [DEPTH_LOG2-1:0]   addrQ;
  logic [DATA_W-1:0]       dataQ;
  logic                    wrQ;
  logic                    misQ;
  logic                    req;
  logic                    accept;
  logic                    commit;
  logic                    misAlign;
  logic [DATA_W-1:0]       mem [DEPTH];

  // Byte-address bits above the word index are dropped so accesses wrap modulo DEPTH.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{aluOut[ADDR_W-1:DEPTH_LOG2+1], aluOut[0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misAlign = aluOut[0];
  assign err      = (state == DONE) & misQ;
`else
  assign misAlign = 1'b0;
  assign err      = 1'b0;
`endif

  assign req  = (memRead | memWrite) & ~halt;
  assign done = (state == DONE);

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        stall = req & rst;
        if (req) begin
          accept    = 1'b1;
          nextState = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (counter == 4'd0) begin
          commit    = 1'b1;
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      counter   <= 4'd0;
      addrQ     <= '0;
      dataQ     <= '0;
      wrQ       <= 1'b0;
      misQ      <= 1'b0;
      memoryOut <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        addrQ   <= aluOut[DEPTH_LOG2:1];
        dataQ   <= wrData;
        wrQ     <= memWrite;
        misQ    <= misAlign;
        counter <= LAT_M1;
      end else if (state == BUSY && counter != 4'd0) begin
        counter <= counter - 4'd1;
      end
      if (commit && !wrQ && !misQ)
        memoryOut <= mem[addrQ];
    end
  end

  // Array is deliberately not reset; a reset forces IDLE so an in-flight store never commits.
  always_ff @(posedge clk) begin
    if (commit && wrQ && !misQ)
      mem[addrQ] <= dataQ;
  end

endmodule

// File: tb/tb_memory_mc.sv
// tb/tb_memory_mc.sv - self-checking bench for memory_mc
`timescale 1ns/1ps
module tb_memory_mc;

  localparam int LATENCY = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] aluOut = '0;
  logic [15:0] wrData = '0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] memoryOut;
  logic        stall;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] expOut;
    logic        expErr;
  } vec_t;

  vec_t vecs[10];

  memory_mc #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .aluOut(aluOut), .wrData(wrData),
    .memRead(memRead), .memWrite(memWrite), .halt(halt),
    .memoryOut(memoryOut), .stall(stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one request, keeps it asserted through DONE, and checks timing and results.
  task automatic doAccess(input string name, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] data,
                          input logic [15:0] expOut, input logic expErr, input int haltAt);
    int stallCnt;
    int doneAt;
    memRead = rd; memWrite = wr; aluOut = addr; wrData = data; halt = 1'b0;
    #1;
    stallCnt = 0;
    doneAt = -1;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        doneAt = c;
        break;
      end
      if (stall) stallCnt++;
      @(posedge clk); #1;
      if (c + 1 == haltAt) halt = 1'b1;
      #1;
    end
    chk({name, "_doneAt"}, 32'(doneAt), 32'(LATENCY + 1));
    chk({name, "_stallCycles"}, 32'(stallCnt), 32'(LATENCY + 1));
    chk({name, "_stallAtDone"}, {31'd0, stall}, 32'd0);
    chk({name, "_memoryOut"}, {16'd0, memoryOut}, {16'd0, expOut});
    chk({name, "_err"}, {31'd0, err}, {31'd0, expErr});
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h0004, 16'h1234, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h0804, 16'h0000, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'h0020, 16'h5555, 16'h1234, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 16'h0030, 16'h0F0F, 16'h1234, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0F0F, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'h0031, 16'h7777, 16'h0F0F, ALIGN};
    vecs[8] = '{1'b1, 1'b0, 16'h0030, 16'h0000, ALIGN ? 16'h0F0F : 16'h7777, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 16'h0031, 16'h0000, ALIGN ? 16'h0F0F : 16'h7777, ALIGN};

    // Reset state, with a request pending to prove stall is gated.
    memRead = 1'b1;
    aluOut  = 16'h0010;
    @(posedge clk); #1;
    chk("reset_memoryOut", {16'd0, memoryOut}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    memRead = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_done", {31'd0, done}, 32'd0);

    // Vectors run back-to-back: each starts the cycle after the previous DONE.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      doAccess($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
               vecs[i].data, vecs[i].expOut, vecs[i].expErr, -1);
    end

    // halt in IDLE blocks acceptance entirely.
    @(posedge clk); #1;
    memRead = 1'b1; memWrite = 1'b0; aluOut = 16'h0010; halt = 1'b1;
    #1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("haltIdle_stall%0d", c), {31'd0, stall}, 32'd0);
      chk($sformatf("haltIdle_done%0d", c), {31'd0, done}, 32'd0);
      @(posedge clk); #2;
    end
    chk("haltIdle_memoryOut", {16'd0, memoryOut}, {16'd0, ALIGN ? 16'h0F0F : 16'h7777});
    memRead = 1'b0; halt = 1'b0;

    // halt raised in BUSY does not disturb the in-flight load.
    @(posedge clk); #1;
    doAccess("haltBusy", 1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0, 1);
    memRead = 1'b0; halt = 1'b0;

    // Reset in the last BUSY cycle of a store aborts it.
    @(posedge clk); #1;
    memWrite = 1'b1; aluOut = 16'h0020; wrData = 16'hAAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midRst_memoryOut", {16'd0, memoryOut}, 32'd0);
    chk("midRst_stall", {31'd0, stall}, 32'd0);
    chk("midRst_done", {31'd0, done}, 32'd0);
    chk("midRst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    chk("midRst_heldStall", {31'd0, stall}, 32'd0);
    memWrite = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("postRst_done", {31'd0, done}, 32'd0);
    doAccess("midRst_load", 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0, -1);
    memRead = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
